uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  8N1 UART receiver, the receive end of the tx link driven by the top-level transmitter (uart_txd).
//  Samples an asynchronous serial line mid-bit and delivers each received byte as a 1-cycle valid strobe.
//  Flags bad stop bits (framing error) and rejects start-bit glitches.
//  Sits beside the transmitter under top; its byte output feeds the operand latch path.
// PARAMETERS
//  CLK_FREQ   50_000_000  system clock frequency, Hz
//  BAUD_RATE  115_200     serial bit rate, bits/s
//  DATA_BITS  8           data bits per frame, LSB first; legal range 5..8
//  Derived:   CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division, must be >= 4)
// PORTS
//  clk           in   1          system clock, rising edge
//  reset_n       in   1          asynchronous active-low reset
//  uart_rxd      in   1          serial input, idle high, asynchronous to clk
//  rx_data       out  DATA_BITS  last correctly framed byte
//  rx_valid      out  1          1-cycle pulse: rx_data just updated
//  rx_frame_err  out  1          1-cycle pulse: stop bit sampled low
//  rx_busy       out  1          high while any state other than IDLE
// BEHAVIOUR
//  Reset (async, reset_n=0): rx_data=0, rx_valid=0, rx_frame_err=0, rx_busy=0, state=IDLE,
//   counters=0, both synchronizer flops=1 (line idle). Deasserting reset mid-frame discards the frame.
//  uart_rxd passes a 2-flop synchronizer; every reference below to rxd means the synchronized value.
//  bit_cnt counts 0..CLKS_PER_BIT-1; bit_idx counts 0..DATA_BITS-1.
//  FSM:
//   IDLE:  rx_busy=0; rxd==0 -> START, bit_cnt=0.
//   START: bit_cnt runs to (CLKS_PER_BIT/2)-1; at that cycle rxd==0 -> DATA (bit_cnt=0, bit_idx=0),
//          rxd==1 -> IDLE (glitch, no strobe).
//   DATA:  each time bit_cnt reaches CLKS_PER_BIT-1, sample rxd into shift reg (LSB first), bit_cnt=0;
//          after sample of bit_idx==DATA_BITS-1 -> STOP, else bit_idx++.
//   STOP:  at bit_cnt==CLKS_PER_BIT-1 sample rxd:
//          1 -> rx_data<=shift reg, rx_valid=1 next cycle, -> IDLE;
//          0 -> rx_frame_err=1 next cycle, rx_data unchanged, -> BREAK.
//   BREAK: hold until rxd==1, then -> IDLE (no strobe; prevents a held-low line creating false frames).
//  Strobes: rx_valid and rx_frame_err are registered, exactly 1 cycle wide, never both high.
//  rx_data holds its value until the next valid frame; it is stable whenever rx_valid is high.
//  Latency: rx_valid rises 1 cycle after the mid-stop-bit sample (~9.5 bit times after the start edge,
//   plus 2 synchronizer cycles).
//  A new start edge is accepted in the first IDLE cycle after STOP (back-to-back frames with no gap).
//  rxd transitions during DATA/STOP between sample points are ignored (no resync mid-frame).
// TESTING (CLK_FREQ=10_000_000, BAUD_RATE=1_000_000 -> CLKS_PER_BIT=10, DATA_BITS=8)
//  1. Reset check: reset_n=0 with uart_rxd=0 -> all outputs 0, state IDLE; release with rxd=1 -> no strobe.
//  2. Send 0xA5 framed 8N1 -> rx_valid exactly 1 cycle, rx_data=0xA5, rx_frame_err=0, rx_busy low afterwards.
//  3. Back-to-back 0x00 then 0xFF with no idle gap -> two rx_valid pulses, data 0x00 then 0xFF.
//  4. 0x3C with stop bit forced 0, line held low 30 cycles -> rx_frame_err 1 cycle, rx_data unchanged,
//     no rx_valid; after line returns high, 0x55 received correctly.
//  5. 3-cycle low glitch on idle line -> returns to IDLE, no rx_valid/rx_frame_err.
//  6. reset_n pulsed low mid-DATA of 0x81 -> outputs 0 immediately; next full 0x42 frame received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: 2-flop synchronizer, mid-bit sampling,
// glitch rejection on start, framing-error strobe and break hold.
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t state, state_nxt;

    logic                 rxd_meta;
    logic                 rxd;
    logic [CW-1:0]        bit_cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 tick;
    logic                 half;
    logic                 last_bit;

    // Synchronizer flops reset high so a released reset never sees a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta <= 1'b1;
            rxd      <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd      <= rxd_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!rxd) state_nxt = START;
            START:   if (half) state_nxt = rxd ? IDLE : DATA;
            DATA:    if (tick && last_bit) state_nxt = STOP;
            STOP:    if (tick) state_nxt = rxd ? IDLE : BRK;
            BRK:     if (rxd) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tick     = (bit_cnt == CNT_LAST);
        half     = (bit_cnt == CNT_HALF);
        last_bit = (bit_idx == IDX_LAST);
        rx_busy  = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt      <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            unique case (state)
                IDLE, BRK: begin
                    bit_cnt <= '0;
                    bit_idx <= '0;
                end
                START: begin
                    bit_idx <= '0;
                    if (half) bit_cnt <= '0;
                    else      bit_cnt <= bit_cnt + CW'(1);
                end
                DATA: begin
                    if (tick) begin
                        bit_cnt <= '0;
                        shift   <= {rxd, shift[DATA_BITS-1:1]};
                        if (!last_bit) bit_idx <= bit_idx + IW'(1);
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (tick) begin
                        bit_cnt <= '0;
                        if (rxd) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                default: bit_cnt <= '0;
            endcase
        end
    end

endmodule
